// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and constants for the direct-mapped instruction cache.
//   word_t         : 32-bit instruction/data word
//   icachef_t      : fetch address split {tag, idx, bytoff} for the default 16 sets
//   icache_frame_t : one cache frame {valid, tag, data}
//   icache_state_t : miss-handling FSM states
package cpu_types_pkg;
    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = 4;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  bytoff;
    } icachef_t;

    typedef struct packed {
        logic        valid;
        logic [25:0] tag;
        word_t       data;
    } icache_frame_t;

    typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and memory-side signals of the instruction cache.
//   datapath : imemREN, imemaddr -> cache ; ihit, imemload <- cache
//   memory   : iREN, iaddr <- cache ; iwait, iload -> cache
//   slave modport is the cache's view, master modport is the environment's view.
interface icache_dm_if #(parameter int WORD_W = 32);
    logic              imemREN;
    logic [31:0]       imemaddr;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              iREN;
    logic [31:0]       iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_frame_array.sv
// icache_frame_array: SETS-entry frame store, synchronous write, asynchronous read.
//   CLK, nRST            : clock, synchronous active-low reset (clears valid bits only)
//   wen, idx, wtag, wdata: fill of frame[idx]
//   rvalid, rtag, rdata  : combinational contents of frame[idx]
module icache_frame_array #(
    parameter  int SETS   = 16,
    parameter  int TAG_W  = 26,
    parameter  int WORD_W = 32,
    localparam int IDX_W  = $clog2(SETS)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              wen,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [WORD_W-1:0] wdata,
    output logic              rvalid,
    output logic [TAG_W-1:0]  rtag,
    output logic [WORD_W-1:0] rdata
);
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [WORD_W-1:0] data [SETS];

    // Reset has priority, so a fill completing in a reset cycle is dropped.
    always_ff @(posedge CLK) begin
        if (!nRST) valid <= '0;
        else if (wen) valid[idx] <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (wen) begin
            tags[idx] <= wtag;
            data[idx] <= wdata;
        end
    end

    assign rvalid = valid[idx];
    assign rtag   = tags[idx];
    assign rdata  = data[idx];
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with single-word miss fill.
//   CLK, nRST : clock, synchronous active-low reset
//   bus       : icache_dm_if.slave (datapath fetch port + memory read port)
//   hit_count, miss_count : present only when ICACHE_STATS_EN is defined
module icache_dm
    import cpu_types_pkg::*;
#(
    parameter int SETS   = ICACHE_SETS,
    parameter int WORD_W = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    icache_dm_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t     state, next;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag, rtag;
    logic [WORD_W-1:0] rdata;
    logic              rvalid, hit, fill;

    assign idx  = bus.imemaddr[IDX_W+1:2];
    assign tag  = bus.imemaddr[31:IDX_W+2];
    assign hit  = bus.imemREN && rvalid && (rtag == tag);
    assign fill = (state == FETCH) && bus.imemREN && !bus.iwait;

    icache_frame_array #(.SETS(SETS), .TAG_W(TAG_W), .WORD_W(WORD_W)) frames (
        .CLK    (CLK),
        .nRST   (nRST),
        .wen    (fill),
        .idx    (idx),
        .wtag   (tag),
        .wdata  (bus.iload),
        .rvalid (rvalid),
        .rtag   (rtag),
        .rdata  (rdata)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else state <= next;
    end

    // FETCH ends on completion or when the datapath withdraws its request.
    always_comb begin
        next = state;
        next = (state == IDLE) ? ((bus.imemREN && !hit) ? FETCH : IDLE)
                               : ((!bus.imemREN || !bus.iwait) ? IDLE : FETCH);
    end

    always_comb begin
        bus.ihit     = hit;
        bus.imemload = rdata;
        bus.iREN     = (state == FETCH) && bus.imemREN;
        bus.iaddr    = (state == FETCH) ? {bus.imemaddr[31:2], 2'b00} : bus.imemaddr;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            hit_count  <= hit_count + 32'(hit);
            miss_count <= miss_count + 32'(state == IDLE && next == FETCH);
        end
    end
`endif
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the datapath's instruction fetch port and the memory controller's instruction port.
- Consumes the datapath fetch request (imemREN, imemaddr). Returns imemload and ihit.
- On a miss, fetches one word from memory through an iREN/iwait handshake and fills the frame.
- Single-cycle hit path; miss latency is set by memory wait states.

Parameters:
- SETS, 16, number of frames; power of two; index width IDX_W = log2(SETS).
- WORD_W, 32, instruction/word width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  synchronous active-low reset, sampled on rising CLK.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; word aligned.
- ihit  out  1  fetch data valid this cycle.
- imemload  out  32  instruction word; valid only when ihit=1.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address.
- iwait  in  1  memory busy; iload valid in any cycle where iREN=1 and iwait=0.
- iload  in  32  memory read data.

Behaviour:
- Address split: tag = addr[31:IDX_W+2], index = addr[IDX_W+1:2], byte offset = addr[1:0] (ignored).
- Frame storage: valid bit, tag, and 32-bit data per frame. All valid bits clear on reset. Tag and data are not reset.
- FSM states: IDLE, FETCH. Reset state is IDLE.
- Hit is combinational in any state: ihit = imemREN & valid[index] & tag match. imemload = data[index].
- On a hit, no state change and no memory request.
- IDLE → FETCH when imemREN=1 and no hit. The transition occurs on the next edge; that cycle ihit=0 and iREN=0.
- In FETCH:
  - iREN = imemREN; iaddr = imemaddr, word aligned with [1:0] forced to 0.
  - When iREN=1 and iwait=0: write valid=1, tag, and data=iload into frame[index]; go to IDLE.
  - The following cycle hits, so a miss costs (memory wait cycles + 2) cycles.
- Fill data is not forwarded combinationally: ihit=0 during the fill cycle.
- FETCH with imemREN=0 (request withdrawn): iREN=0, no fill, return to IDLE next edge.
- If imemaddr changes during FETCH, iaddr follows it. The fill uses the address present in the completion cycle. The memory controller holds no address state, so this is safe.
- Conflict miss (same index, different tag): overwrite the frame. No write-back, because the cache is read-only.
- In IDLE, iREN=0 and iaddr=imemaddr. No combinational path from iload to ihit.
- Reset asserted mid-FETCH: the next edge forces IDLE and clears all valid bits. iREN is 0 from that edge. A completing memory response in that same cycle is discarded.
- Output reset values, with valid clear: ihit=0, iREN=0, imemload=don't-care (drive data[index]).

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined:
  - Extra outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per cycle with ihit=1.
  - miss_count increments once per IDLE→FETCH transition.
  - Both counters wrap at 2^32.
- When undefined: no counters, no extra ports; functionally identical otherwise.

Decomposition:
- In cpu_types_pkg:
  - typedef icachef_t: packed struct {tag[25:0], idx[3:0], bytoff[1:0]}, matching the default SETS.
  - typedef icache_frame_t: {valid, tag[25:0], data word_t}.
  - enum icache_state_t {IDLE, FETCH}.
  - constants ICACHE_SETS=16, ICACHE_IDX_W=4.
- Sub-module icache_frame_array:
  - SETS-entry array with synchronous write and asynchronous read.
  - Valid bits cleared on nRST.
  - Top level keeps the FSM, hit compare, and optional counters.

Test Plan:
- Cold miss: reset, then imemREN=1, imemaddr=0x0000_0040, memory returns 0x2002_0005 after 3 iwait cycles. Required: iREN=1 with iaddr=0x40 during the wait; ihit=1 and imemload=0x2002_0005 exactly one cycle after the fill; miss_count=1.
- Repeat hit: same address again. Required: ihit=1 in the same cycle, iREN=0; hit_count increments each held cycle.
- Conflict: fetch 0x40 (fill 0xAAAA_AAAA), then 0x80 (same index 0, fill 0xBBBB_BBBB), then 0x40 again. Required: third access misses and refetches 0xAAAA_AAAA.
- Aliasing across all frames: fill 0x00..0x3C (all 16 indices). Then re-read all 16. Required: 16 hits with correct data; no iREN asserted.
- Withdrawn request: miss on 0x100, drop imemREN after 1 iwait cycle. Required: iREN=0 that cycle; state returns to IDLE; frame 0 not written; later 0x100 misses again.
- Reset mid-fetch: assert nRST=0 in the cycle iwait falls with iload=0xDEAD_BEEF. Required: fill discarded; after release, 0x40 misses; counters read 0.
